// File: rtl/ucie_ctl_adapter_sb_msg_assembler.sv
// Assembles NC-bit RDI sideband config beats into a 64-bit header plus optional
// 64-bit data phase, hands it to the decoder over valid/ready, and returns the credit.
module ucie_ctl_adapter_sb_msg_assembler #(
  parameter int NC = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pl_cfg_vld,
  input  logic [NC-1:0]   i_pl_cfg,
  output logic            o_lp_cfg_crd,
  output logic            o_msg_vld,
  input  logic            i_msg_rdy,
  output logic [127:0]    o_msg,
  output logic            o_msg_has_data,
  output logic            o_err_ovf
);

  localparam int B  = 64 / NC;
  localparam int CW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [1:0] {HDR, DATA, FULL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     hdr_q, hdr_d, dat_q, dat_d;
  logic [63:0]     hdr_ins, dat_ins;
  logic            has_data_q, has_data_d;
  logic            msg_vld_q, msg_vld_d;
  logic            crd_q, crd_d;
  logic            ovf_q, ovf_d;
  logic            last_beat;
  logic            data_op;

  // Current beat merged into each phase at the counter's slot, LSB first.
  always_comb begin
    hdr_ins = hdr_q;
    dat_ins = dat_q;
    for (int k = 0; k < B; k++) begin
      if (cnt_q == CW'(k)) begin
        hdr_ins[k*NC +: NC] = i_pl_cfg;
        dat_ins[k*NC +: NC] = i_pl_cfg;
      end
    end
  end

  assign last_beat = (cnt_q == CW'(B - 1));

  // Opcode is taken from the header including this beat (matters for NC=64).
  always_comb begin
    case (hdr_ins[4:0])
      5'b00001, 5'b00101, 5'b01001, 5'b01101,
      5'b10001, 5'b11001, 5'b11011: data_op = 1'b1;
      default:                      data_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    dat_d      = dat_q;
    has_data_d = has_data_q;
    msg_vld_d  = msg_vld_q;
    crd_d      = 1'b0;
    ovf_d      = ovf_q;
    case (state_q)
      HDR: begin
        if (i_pl_cfg_vld) begin
          hdr_d = hdr_ins;
          if (last_beat) begin
            cnt_d = '0;
            if (data_op) begin
              state_d    = DATA;
              has_data_d = 1'b1;
            end else begin
              state_d   = FULL;
              dat_d     = '0;
              msg_vld_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (i_pl_cfg_vld) begin
          dat_d = dat_ins;
          if (last_beat) begin
            cnt_d     = '0;
            state_d   = FULL;
            msg_vld_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FULL: begin
        // Beats here are dropped; the stored message is left untouched.
        if (i_pl_cfg_vld) ovf_d = 1'b1;
        if (msg_vld_q && i_msg_rdy) begin
          state_d    = HDR;
          hdr_d      = '0;
          dat_d      = '0;
          has_data_d = 1'b0;
          msg_vld_d  = 1'b0;
          crd_d      = 1'b1;
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= HDR;
      cnt_q      <= '0;
      hdr_q      <= '0;
      dat_q      <= '0;
      has_data_q <= 1'b0;
      msg_vld_q  <= 1'b0;
      crd_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      dat_q      <= dat_d;
      has_data_q <= has_data_d;
      msg_vld_q  <= msg_vld_d;
      crd_q      <= crd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_lp_cfg_crd   = crd_q;
  assign o_msg_vld      = msg_vld_q;
  assign o_msg          = {dat_q, hdr_q};
  assign o_msg_has_data = has_data_q;
  assign o_err_ovf      = ovf_q;

endmodule

// File: doc/ucie_ctl_adapter_sb_msg_assembler.md
# ucie_ctl_adapter_sb_msg_assembler

Adapter-side receiver for the RDI sideband configuration channel, directly downstream of the PHY sideband message RX stage. Collects NC-bit `pl_cfg` beats into one complete UCIe sideband message: a 64-bit header plus an optional 64-bit data phase. Presents the message to the adapter's sideband message decoder through a valid/ready handshake. Returns the single RDI config credit (`lp_cfg_crd`) to the PHY once the message has been consumed.

## Interface
- NC, default 32: RDI config bus width; legal values 16, 32, 64.
- i_clk  input  1  clock, all logic on rising edge
- i_rst_n  input  1  reset; asynchronous, active-low
- i_pl_cfg_vld  input  1  beat valid from PHY sideband RX stage
- i_pl_cfg  input  NC  beat payload
- o_lp_cfg_crd  output  1  one-cycle credit return pulse to PHY
- o_msg_vld  output  1  complete message available
- i_msg_rdy  input  1  decoder accepts message
- o_msg  output  128  [63:0] header, [127:64] data phase (zero when no data)
- o_msg_has_data  output  1  message carried a data phase
- o_err_ovf  output  1  sticky: beat received while no credit outstanding

## Operation
- Beats per 64-bit phase: B = 64/NC (4, 2 or 1). Beat k of a phase lands in bits [k*NC +: NC] of that phase, LSB first.
- Beat counter width is log2(B), minimum 1 bit. It is cleared at every phase boundary.
- Data-bearing opcodes are header[4:0] in {5'b00001, 5'b00101, 5'b01001, 5'b01101, 5'b10001, 5'b11001, 5'b11011}. All other opcodes are header-only.
- FSM states:
  - HDR (reset state): each valid beat is written into the header field.
    - On the B-th beat, if the opcode is data-bearing, go to DATA.
    - Otherwise go to FULL with the data field zeroed.
  - DATA: each valid beat is written into the data field. On the B-th beat, go to FULL.
  - FULL: o_msg_vld=1 and o_msg is held stable.
    - When o_msg_vld and i_msg_rdy are both high, the message is drained: go to HDR, clear both fields and o_msg_has_data, and schedule a credit pulse.
- Gaps (i_pl_cfg_vld=0) are allowed between beats in HDR and DATA. A gap holds state and the beat counter.
- The opcode check uses the header as completed by the current beat. For NC=64 this means the incoming beat itself.
- A beat arriving in FULL is an overflow:
  - This applies even if i_msg_rdy=1 in the same cycle.
  - The beat is dropped, o_err_ovf is set and stays set until reset, and the stored message is not modified.
- The upstream stage holds one credit out of reset. No credit pulse is issued at reset.
- Exactly one credit pulse is issued per drained message.

## Timing
- Reset values: o_lp_cfg_crd=0, o_msg_vld=0, o_msg=0, o_msg_has_data=0, o_err_ovf=0. State HDR, counter 0.
- o_msg_vld rises on the cycle after the final beat is sampled. Latency from final beat to valid is 1 cycle.
- o_msg_vld and o_msg are registered. They remain stable while o_msg_vld=1 and i_msg_rdy=0.
- Handshake: a transfer occurs on a rising edge where o_msg_vld=1 and i_msg_rdy=1. o_msg_vld is 0 in the following cycle.
- o_lp_cfg_crd is registered. It is high for exactly the single cycle after the transfer edge.
- A beat sampled in HDR in the cycle of o_lp_cfg_crd is legal and starts the next message.
- o_err_ovf rises the cycle after the offending beat.
- Asserting i_rst_n low mid-message clears everything asynchronously. The partial message is discarded and no credit pulse is generated.

## Test plan
- NC=32, header beats 0x0000_0000, 0x1234_5678 (opcode 0x00, header-only), i_msg_rdy=1 -> o_msg_vld high 1 cycle later, o_msg[63:0]=0x12345678_00000000, o_msg[127:64]=0, o_msg_has_data=0, o_lp_cfg_crd pulses 1 cycle after transfer.
- NC=32, header beat0 0x0000_0005 (CfgWrite32), beat1 0, data beats 0xDEAD_BEEF, 0x0 -> o_msg[95:64]=0xDEADBEEF, o_msg_has_data=1, and o_msg_vld does not rise before the 4th beat.
- NC=32, the 4 beats separated by 3 idle cycles each -> message identical to the back-to-back case, with o_msg_vld 1 cycle after the last beat.
- Hold i_msg_rdy=0 for 10 cycles with o_msg_vld=1, then send a beat -> o_msg unchanged, o_err_ovf=1 and sticky, no credit pulse until rdy rises, and exactly one pulse afterwards.
- Pulse i_rst_n low after 1 of 4 beats, then send a full header-only message -> the clean message is assembled, with no credit pulse from the aborted one.
- Repeat the header-only and data-bearing cases with NC=16 (4 beats/phase) and NC=64 (1 beat/phase). For NC=64, send a data-bearing opcode followed by one data beat -> o_msg_vld 1 cycle after the data beat.
